// File: rtl/dac_spi_tx.sv
// dac_spi_tx: samples a 10-bit waveform word at a fixed rate and sends it to
// a serial DAC as a 16-bit SPI mode-0 frame, then strobes LDAC.
// SCLK, MOSI, CS_N, LDAC_N and BUSY are decoded from registered state, so
// they change only just after clock edges and drop to idle as soon as reset
// is asserted.
module dac_spi_tx #(
   parameter int         CLK_DIV    = 2,
   parameter int         SAMPLE_DIV = 100,
   parameter logic [3:0] CFG        = 4'b0111
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [9:0] waveform_data,
   input  logic       enable,
   output logic       dac_sclk,
   output logic       dac_mosi,
   output logic       dac_cs_n,
   output logic       dac_ldac_n,
   output logic       busy,
   output logic       frame_done,
   output logic       overrun,
   output logic [2:0] dbg_state
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_SETUP = 3'd1,
      S_SHIFT = 3'd2,
      S_CSHI  = 3'd3,
      S_LDAC  = 3'd4
   } state_t;

   localparam int SW = $clog2(SAMPLE_DIV + 1);
   localparam int DW = $clog2(CLK_DIV + 1);

   state_t         r_state;
   state_t         w_next_state;
   logic [SW-1:0]  r_sample_cnt;
   logic [DW-1:0]  r_div;
   logic [4:0]     r_half;
   logic [15:0]    r_shift;
   logic           r_frame_done;
   logic           r_overrun;
   logic           w_tick;
   logic           w_div_last;
   logic           w_in_frame;

   assign w_tick     = enable && (r_sample_cnt == SW'(SAMPLE_DIV - 1));
   assign w_div_last = (r_div == DW'(CLK_DIV - 1));
   assign w_in_frame = (r_state == S_SETUP) || (r_state == S_SHIFT);

   // Sample-rate counter: runs only while enabled, wraps at SAMPLE_DIV-1.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_sample_cnt <= '0;
      end else if (!enable || (r_sample_cnt == SW'(SAMPLE_DIV - 1))) begin
         r_sample_cnt <= '0;
      end else begin
         r_sample_cnt <= r_sample_cnt + SW'(1);
      end
   end

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state logic: every non-idle state advances on the last cycle of a
   // CLK_DIV half-period; SHIFT stays for 32 half-periods.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE:  if (w_tick) w_next_state = S_SETUP;
         S_SETUP: if (w_div_last) w_next_state = S_SHIFT;
         S_SHIFT: if (w_div_last && (r_half == 5'd31)) w_next_state = S_CSHI;
         S_CSHI:  if (w_div_last) w_next_state = S_LDAC;
         S_LDAC:  if (w_div_last) w_next_state = S_IDLE;
         default: w_next_state = S_IDLE;
      endcase
   end

   // Half-period pacing counters and the frame shift register. The shift
   // happens entering each falling half-period for the first 15 bits, so the
   // last bit stays on MOSI through the 16th falling edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_div   <= '0;
         r_half  <= '0;
         r_shift <= '0;
      end else begin
         if ((r_state == S_IDLE) || w_div_last) begin
            r_div <= '0;
         end else begin
            r_div <= r_div + DW'(1);
         end

         if (r_state != S_SHIFT) begin
            r_half <= '0;
         end else if (w_div_last) begin
            r_half <= r_half + 5'd1;
         end

         if ((r_state == S_IDLE) && w_tick) begin
            r_shift <= {CFG, waveform_data, 2'b00};
         end else if ((r_state == S_SHIFT) && w_div_last && !r_half[0] &&
                      (r_half[4:1] != 4'd15)) begin
            r_shift <= {r_shift[14:0], 1'b0};
         end
      end
   end

   // One-cycle status pulses: frame completion and dropped ticks.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_frame_done <= 1'b0;
         r_overrun    <= 1'b0;
      end else begin
         r_frame_done <= (r_state == S_LDAC) && w_div_last;
         r_overrun    <= w_tick && (r_state != S_IDLE);
      end
   end

   assign dac_sclk   = (r_state == S_SHIFT) && !r_half[0];
   assign dac_mosi   = w_in_frame && r_shift[15];
   assign dac_cs_n   = !w_in_frame;
   assign dac_ldac_n = (r_state != S_LDAC);
   assign busy       = (r_state != S_IDLE);
   assign frame_done = r_frame_done;
   assign overrun    = r_overrun;
   assign dbg_state  = r_state;

endmodule

// File: tb/tb_dac_spi_tx.sv
// tb_dac_spi_tx: three dac_spi_tx instances (defaults, SAMPLE_DIV=50, and
// CLK_DIV=1/SAMPLE_DIV=36), exercised one at a time through a shared SPI
// decoder and an expected-frame queue.
module tb_dac_spi_tx;

   typedef struct {
      logic [9:0]  data;
      logic [15:0] frame;
   } vec_t;

   localparam int NV = 6;

   logic        clk;
   logic        rst;
   logic        enable;
   logic [9:0]  waveform_data;
   logic [1:0]  sel;
   logic [2:0]  rst_v;
   logic [2:0]  v_sclk, v_mosi, v_cs, v_ldac, v_busy, v_fd, v_ov;
   logic [2:0]  v_dbg [3];
   logic        m_sclk, m_mosi, m_cs, m_ldac, m_busy, m_fd, m_ov;

   logic [15:0] exp_q[$];
   vec_t        tbl [NV];

   int n_cmp = 0;
   int n_fail = 0;
   int rel_cyc = 0;
   int cur_div = 2;
   bit chk_b2b = 0;

   // monitor state
   logic        prev_sclk = 0, prev_cs = 1, prev_ldac = 1, prev_fd = 0, prev_ov = 0;
   logic [15:0] sh = '0;
   logic [15:0] exp_frame;
   int nbits = 0, cs_low = 0, ldac_low = 0;
   int cs_fall_n = 0, ldac_fall_n = 0, fd_n = 0, ov_n = 0;
   int last_cs_fall = -1, last_fd = -1, last_ov = -1;

   // clock / reset routing
   initial clk = 0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (!rst) rel_cyc <= 0;
      else      rel_cyc <= rel_cyc + 1;
   end

   assign rst_v[0] = rst && (sel == 2'd0);
   assign rst_v[1] = rst && (sel == 2'd1);
   assign rst_v[2] = rst && (sel == 2'd2);

   dac_spi_tx u_dut0 (
      .clk(clk), .rst(rst_v[0]), .waveform_data(waveform_data), .enable(enable),
      .dac_sclk(v_sclk[0]), .dac_mosi(v_mosi[0]), .dac_cs_n(v_cs[0]),
      .dac_ldac_n(v_ldac[0]), .busy(v_busy[0]), .frame_done(v_fd[0]),
      .overrun(v_ov[0]), .dbg_state(v_dbg[0])
   );

   dac_spi_tx #(.CLK_DIV(2), .SAMPLE_DIV(50)) u_dut1 (
      .clk(clk), .rst(rst_v[1]), .waveform_data(waveform_data), .enable(enable),
      .dac_sclk(v_sclk[1]), .dac_mosi(v_mosi[1]), .dac_cs_n(v_cs[1]),
      .dac_ldac_n(v_ldac[1]), .busy(v_busy[1]), .frame_done(v_fd[1]),
      .overrun(v_ov[1]), .dbg_state(v_dbg[1])
   );

   dac_spi_tx #(.CLK_DIV(1), .SAMPLE_DIV(36)) u_dut2 (
      .clk(clk), .rst(rst_v[2]), .waveform_data(waveform_data), .enable(enable),
      .dac_sclk(v_sclk[2]), .dac_mosi(v_mosi[2]), .dac_cs_n(v_cs[2]),
      .dac_ldac_n(v_ldac[2]), .busy(v_busy[2]), .frame_done(v_fd[2]),
      .overrun(v_ov[2]), .dbg_state(v_dbg[2])
   );

   assign m_sclk = v_sclk[sel];
   assign m_mosi = v_mosi[sel];
   assign m_cs   = v_cs[sel];
   assign m_ldac = v_ldac[sel];
   assign m_busy = v_busy[sel];
   assign m_fd   = v_fd[sel];
   assign m_ov   = v_ov[sel];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t rel_cyc=%0d)", name, act, exp, $time, rel_cyc);
      end
   endtask

   // wait at negedges until rel_cyc reaches target, bounded
   task automatic wait_cyc(input int target);
      int guard = 0;
      while ((rel_cyc < target) && (guard < 5000)) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 5000) begin
         n_cmp++;
         n_fail++;
         $display("FAIL wait_timeout: rel_cyc %0d never reached %0d", rel_cyc, target);
      end
   endtask

   // scoreboard / SPI decoder, sampled on the falling clk edge
   always @(negedge clk) begin
      if (prev_cs && !m_cs) begin
         cs_fall_n++;
         if (chk_b2b && (rel_cyc > 40)) check("b2b_gap", rel_cyc - last_fd, 1);
         last_cs_fall = rel_cyc;
         cs_low = 0;
         nbits = 0;
         sh = '0;
      end
      if (!m_cs) begin
         cs_low++;
         if (!prev_sclk && m_sclk) begin
            sh = {sh[14:0], m_mosi};
            nbits++;
         end
      end
      if (!prev_cs && m_cs && rst) begin
         check("frame_bits", nbits, 16);
         check("cs_low_len", cs_low, 33 * cur_div);
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_frame: got %04h expected none", sh);
         end else begin
            exp_frame = exp_q.pop_front();
            check("frame_data", sh, exp_frame);
         end
      end
      if (prev_ldac && !m_ldac) begin
         ldac_fall_n++;
         ldac_low = 1;
      end else if (!m_ldac) begin
         ldac_low++;
      end
      if (!prev_ldac && m_ldac && rst) check("ldac_low_len", ldac_low, cur_div);
      if (m_fd) begin
         fd_n++;
         last_fd = rel_cyc;
         check("fd_busy", m_busy, 0);
         check("frame_len", rel_cyc - last_cs_fall, 35 * cur_div);
         if (prev_fd) check("fd_width", 2, 1);
      end
      if (m_ov) begin
         ov_n++;
         last_ov = rel_cyc;
         if (prev_ov) check("ov_width", 2, 1);
      end
      prev_sclk = m_sclk;
      prev_cs   = m_cs;
      prev_ldac = m_ldac;
      prev_fd   = m_fd;
      prev_ov   = m_ov;
   end

   // watchdog
   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   // stimulus
   initial begin
      int   ov_base, cs_base, ldac_base, fd_base;
      logic [9:0] d;

      tbl[0] = '{10'h2A5, 16'h7A94};
      tbl[1] = '{10'h000, 16'h7000};
      tbl[2] = '{10'h3FF, 16'h7FFC};
      tbl[3] = '{10'h155, 16'h7554};
      for (int i = 4; i < NV; i++) begin
         d = 10'($urandom_range(0, 1023));
         tbl[i] = '{d, {4'b0111, d, 2'b00}};
      end

      // ---------------- defaults instance ----------------
      sel = 2'd0; cur_div = 2; chk_b2b = 0;
      rst = 0; enable = 1; waveform_data = tbl[0].data;
      repeat (3) @(negedge clk);
      check("rst_sclk", m_sclk, 0);
      check("rst_mosi", m_mosi, 0);
      check("rst_cs_n", m_cs, 1);
      check("rst_ldac_n", m_ldac, 1);
      check("rst_busy", m_busy, 0);
      check("rst_fd", m_fd, 0);
      check("rst_ov", m_ov, 0);
      check("rst_state", v_dbg[0], 0);

      exp_q.push_back(tbl[0].frame);
      rst = 1;
      for (int i = 0; i < NV; i++) begin
         wait_cyc(100 * (i + 1) + 10);
         check("cs_fall_cyc", last_cs_fall, 100 * (i + 1));
         if (i > 0) check("fd_cyc", last_fd, 100 * i + 70);
         if (i + 1 < NV) begin
            waveform_data = tbl[i + 1].data;
            exp_q.push_back(tbl[i + 1].frame);
         end else begin
            d = 10'($urandom_range(0, 1023));
            waveform_data = d;
            exp_q.push_back({4'b0111, d, 2'b00});
         end
      end

      // enable drop 10 cycles into the frame started at 700
      wait_cyc(710);
      enable = 0;
      waveform_data = 10'($urandom_range(0, 1023));
      cs_base = cs_fall_n;
      wait_cyc(900);
      check("en_drop_fd", last_fd, 770);
      check("en_drop_no_cs", cs_fall_n, cs_base);
      d = 10'h0F0;
      waveform_data = d;
      exp_q.push_back({4'b0111, d, 2'b00});
      enable = 1;
      wait_cyc(1010);
      check("reen_cs_fall", last_cs_fall, 1000);
      wait_cyc(1080);
      check("reen_fd", last_fd, 1070);

      // reset at SCLK rising edge 8 of the frame starting at 1100
      waveform_data = 10'h1C3;
      wait_cyc(1130);
      check("edge8_sclk", m_sclk, 1);
      ldac_base = ldac_fall_n;
      fd_base = fd_n;
      #2;
      rst = 0;
      #1;
      check("mid_rst_cs_n", m_cs, 1);
      check("mid_rst_sclk", m_sclk, 0);
      check("mid_rst_busy", m_busy, 0);
      check("mid_rst_mosi", m_mosi, 0);
      repeat (4) @(negedge clk);
      check("mid_rst_no_ldac", ldac_fall_n, ldac_base);
      check("mid_rst_no_fd", fd_n, fd_base);
      waveform_data = tbl[0].data;
      exp_q.push_back(tbl[0].frame);
      rst = 1;
      wait_cyc(110);
      check("post_rst_cs_fall", last_cs_fall, 100);
      wait_cyc(180);
      check("post_rst_fd", last_fd, 170);
      enable = 0;
      check("A_overruns", ov_n, 0);
      check("A_queue_empty", exp_q.size(), 0);

      // ---------------- SAMPLE_DIV=50: overruns ----------------
      @(negedge clk);
      rst = 0;
      @(negedge clk);
      sel = 2'd1; cur_div = 2;
      repeat (2) @(negedge clk);
      ov_base = ov_n;
      enable = 1;
      d = 10'($urandom_range(0, 1023));
      waveform_data = d;
      exp_q.push_back({4'b0111, d, 2'b00});
      rst = 1;
      for (int k = 1; k <= 7; k++) begin
         wait_cyc(50 * k + 10);
         if (k == 7) begin
            enable = 0;
         end else begin
            d = 10'($urandom_range(0, 1023));
            waveform_data = d;
            if (((k + 1) % 2) == 1) exp_q.push_back({4'b0111, d, 2'b00});
         end
      end
      wait_cyc(430);
      check("B_overrun_count", ov_n - ov_base, 3);
      check("B_last_overrun", last_ov, 300);
      check("B_last_fd", last_fd, 420);
      check("B_queue_empty", exp_q.size(), 0);

      // ---------------- CLK_DIV=1, SAMPLE_DIV=36: back-to-back ----------------
      @(negedge clk);
      rst = 0;
      @(negedge clk);
      sel = 2'd2; cur_div = 1;
      repeat (2) @(negedge clk);
      ov_base = ov_n;
      cs_base = cs_fall_n;
      chk_b2b = 1;
      enable = 1;
      d = 10'($urandom_range(0, 1023));
      waveform_data = d;
      exp_q.push_back({4'b0111, d, 2'b00});
      rst = 1;
      for (int k = 1; k <= 5; k++) begin
         wait_cyc(36 * k + 5);
         if (k == 5) begin
            enable = 0;
         end else begin
            d = 10'($urandom_range(0, 1023));
            waveform_data = d;
            exp_q.push_back({4'b0111, d, 2'b00});
         end
      end
      wait_cyc(220);
      check("C_no_overrun", ov_n - ov_base, 0);
      check("C_frames", cs_fall_n - cs_base, 5);
      check("C_last_fd", last_fd, 215);
      check("C_queue_empty", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/dac_spi_tx.md
# dac_spi_tx

Downstream output stage of the arbitrary waveform generator. It samples the 10-bit `waveform_data` word from the waveform generator at a fixed sample rate and serialises each sample as a 16-bit SPI frame to an external 10-bit serial DAC, then pulses LDAC so the DAC output updates. It replaces a parallel DAC bus with a 4-wire serial interface and reports frame completion and sample overruns.

## Interface
- `CLK_DIV`, default 2: clk cycles per SCLK half-period; must be at least 1.
- `SAMPLE_DIV`, default 100: clk cycles per sample tick; must be at least 35*CLK_DIV+1 for overrun-free operation.
- `CFG`, default 4'b0111: DAC config nibble, frame bits [15:12] (channel A, buffered, 1x gain, active).

- `clk`  input  1  system clock; all logic on its rising edge.
- `rst`  input  1  asynchronous, active-low reset.
- `waveform_data`  input  10  sample from the waveform generator; captured at each sample tick.
- `enable`  input  1  when high, the sample counter runs; when low, the counter is held at 0.
- `dac_sclk`  output  1  SPI clock, idle low (mode 0).
- `dac_mosi`  output  1  SPI data, MSB first.
- `dac_cs_n`  output  1  DAC chip select, active low.
- `dac_ldac_n`  output  1  DAC latch strobe, active low.
- `busy`  output  1  high while a frame is in progress (any state other than IDLE).
- `frame_done`  output  1  1-cycle pulse when a frame completes.
- `overrun`  output  1  1-cycle pulse when a tick is dropped because the block is busy.

## Operation
- **Frame format:** {CFG[3:0], waveform_data[9:0], 2'b00}, 16 bits, sent MSB first.
- **Sample counter:**
  - Counts 0..SAMPLE_DIV-1 while `enable` is high, then wraps to 0.
  - The tick is asserted in the cycle where count == SAMPLE_DIV-1 and `enable` = 1.
  - When `enable` is low, the counter is cleared to 0 and no ticks occur.
- **FSM states:** IDLE, SETUP, SHIFT, CSHI, LDAC. A half-period counter (0..CLK_DIV-1) paces every state except IDLE.
  - **IDLE:** on tick, load the shift register with the frame, drive `dac_cs_n`=0 and `dac_mosi`=frame[15], go to SETUP.
  - **SETUP:** lasts CLK_DIV cycles, with `dac_sclk`=0. Then go to SHIFT.
  - **SHIFT:** 32 half-periods.
    - Odd half-periods: `dac_sclk`=1.
    - Even half-periods: `dac_sclk`=0, and `dac_mosi` advances to the next bit at the start of each low half-period after the first 15 rising edges.
    - After the 16th falling edge, `dac_mosi` holds frame[0]. Then go to CSHI.
  - **CSHI:** `dac_cs_n`=1, `dac_mosi`=0, for CLK_DIV cycles. Then go to LDAC.
  - **LDAC:** `dac_ldac_n`=0 for CLK_DIV cycles. Then return to IDLE, and pulse `frame_done` for one cycle.
- **Tick while not IDLE:** the sample is dropped, `overrun` pulses for 1 cycle, and the current frame is unaffected.
- **`enable` falling mid-frame:** the in-flight frame completes normally, and no new ticks occur.
- **`waveform_data` changes:** changes after the tick cycle do not affect the frame in flight.

## Timing
- **Reset values (asynchronous, while `rst`=0):**
  - `dac_sclk`=0, `dac_mosi`=0, `dac_cs_n`=1, `dac_ldac_n`=1.
  - `busy`=0, `frame_done`=0, `overrun`=0.
  - State IDLE, all counters 0.
- **Reset mid-frame:** outputs return to the reset values immediately, the frame is aborted, and there is no LDAC pulse.
- **First tick:** after reset release with `enable`=1, the first tick occurs on the SAMPLE_DIV-th clock edge. Subsequent ticks follow every SAMPLE_DIV cycles.
- **Frame timeline,** with edge E0 = the tick edge:
  - `dac_cs_n` falls and `busy` rises after E0.
  - SCLK rising edge k (k = 1..16) occurs after E0+(2k-1)*CLK_DIV.
  - SCLK falling edge k occurs after E0+2k*CLK_DIV.
  - `dac_cs_n` rises after E0+33*CLK_DIV.
  - `dac_ldac_n` is low from E0+34*CLK_DIV to E0+35*CLK_DIV.
  - After E0+35*CLK_DIV: `busy`=0 and `frame_done`=1 for one cycle.
  - Frame length is 35*CLK_DIV cycles.
- **Data setup/hold:** `dac_mosi` is stable for at least CLK_DIV cycles before and after each SCLK rising edge.
- **Tick on the cycle busy falls:** the block is IDLE again in the cycle after the `frame_done` edge. A tick arriving in that cycle starts a new frame, with no overrun.

## Test plan
- Defaults, `waveform_data`=10'h2A5, `enable`=1 → after 100 cycles, SPI decoder on rising SCLK captures 16'h7A94. `dac_cs_n` is low for 66 cycles, `dac_ldac_n` is low for 2 cycles, and `frame_done` pulses at cycle 170 from reset release.
- Sweep `waveform_data` 0, 10'h3FF, 10'h155 across three consecutive ticks → frames 16'h7000, 16'h7FFC, 16'h7554. Every frame is exactly 70 cycles and the frames are spaced 100 cycles apart.
- SAMPLE_DIV=50, CLK_DIV=2 → every second tick is dropped with an `overrun` pulse. Transmitted frames are never truncated, and `dac_cs_n` stays low throughout each 66-cycle window.
- `enable` dropped 10 cycles into a frame → the frame completes with correct data, then there are no further `dac_cs_n` edges. Re-enabling gives the next tick 100 cycles later.
- Assert `rst`=0 at SCLK rising edge 8 → in the same cycle, `dac_cs_n`=1, `dac_sclk`=0, `busy`=0, and no LDAC pulse. After release, the normal first frame follows.
- CLK_DIV=1, SAMPLE_DIV=36 → back-to-back 35-cycle frames with no `overrun`, and each `frame_done` is followed by the next `dac_cs_n` fall one cycle later.
